ramp_adc_ctrl: RTL and testbench

- Single-slope ramp ADC controller that sits directly downstream of the 2-flop comparator synchronizer.
- Steps an R2R DAC code upward from 0 and holds each code for a fixed settle window.
- Samples the synchronized comparator once per step, at the end of the hold window.
- Captures the first code at which the comparator trips and presents it as a registered sample with a one-cycle valid pulse.

---
 rtl/ramp_adc_ctrl.sv | 105 ++++++++++
 tb/tb_ramp_adc_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ramp_adc_ctrl.sv
// Single-slope ramp ADC controller: steps an R2R DAC code upward, samples the
// synchronized comparator at the end of each settle window, captures the trip code.
module ramp_adc_ctrl #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             comp_sync,
  output logic [WIDTH-1:0] dac_code,
  output logic [WIDTH-1:0] sample,
  output logic             sample_valid,
  output logic             over_range,
  output logic             busy
);

  localparam int unsigned      CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] CODE_MAX = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] dac_nxt, sample_nxt;
  logic             over_nxt, valid_nxt, busy_nxt;

  // State and registered outputs; reset discards any partial conversion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      dac_code     <= '0;
      sample       <= '0;
      over_range   <= 1'b0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      dac_code     <= dac_nxt;
      sample       <= sample_nxt;
      over_range   <= over_nxt;
      sample_valid <= valid_nxt;
      busy         <= busy_nxt;
    end
  end

  // Next-state logic; comp_sync is only looked at on the last cycle of each hold window.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dac_nxt    = dac_code;
    sample_nxt = sample;
    over_nxt   = over_range;

    case (state)
      IDLE: begin
        dac_nxt = '0;
        cnt_nxt = '0;
        if (enable) state_nxt = RAMP;
      end

      RAMP: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (comp_sync) begin
            sample_nxt = dac_code;
            over_nxt   = 1'b0;
            state_nxt  = DONE;
          end else if (dac_code == CODE_MAX) begin
            sample_nxt = CODE_MAX;
            over_nxt   = 1'b1;
            state_nxt  = DONE;
          end else begin
            dac_nxt = dac_code + WIDTH'(1);
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      DONE: begin
        dac_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = enable ? RAMP : IDLE;
      end

      default: begin
        dac_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase

    valid_nxt = (state_nxt == DONE);
    busy_nxt  = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_ramp_adc_ctrl.sv
// Directed bench for ramp_adc_ctrl (WIDTH=4, SETTLE_CYCLES=4) with a
// threshold comparator model delayed through two flops.
module tb_ramp_adc_ctrl;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned SETTLE = 4;

  logic             clk;
  logic             reset;
  logic             enable;
  logic             comp_sync;
  logic [WIDTH-1:0] dac_code;
  logic [WIDTH-1:0] sample;
  logic             sample_valid;
  logic             over_range;
  logic             busy;

  // 0: threshold model, 1: forced high, 2: forced low
  int               comp_mode;
  logic [4:0]       thr;
  logic             glitch;
  logic             s1, s2;

  int n_chk;
  int n_fail;
  int cyc;
  int bad;

  ramp_adc_ctrl #(
    .WIDTH        (WIDTH),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .comp_sync   (comp_sync),
    .dac_code    (dac_code),
    .sample      (sample),
    .sample_valid(sample_valid),
    .over_range  (over_range),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    s1 <= ({1'b0, dac_code} >= thr);
    s2 <= s1;
  end

  always_comb begin
    comp_sync = 1'b0;
    if (comp_mode == 1)      comp_sync = 1'b1;
    else if (comp_mode == 2) comp_sync = 1'b0;
    else                     comp_sync = s2 | glitch;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int max_cyc, output int n);
    n = 0;
    while (sample_valid !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
  endtask

  // Checks the staircase dac_code == i/SETTLE for n cycles, optional glitch at cycle g.
  task automatic ramp_check(input int n, input int g);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("stair_dac_%0d", i), 32'(dac_code), 32'(i / SETTLE));
      chk($sformatf("stair_novalid_%0d", i), 32'(sample_valid), 32'd0);
      glitch = (i == g);
      step();
    end
    glitch = 1'b0;
  endtask

  initial begin
    clk       = 1'b0;
    reset     = 1'b1;
    enable    = 1'b0;
    comp_mode = 1;
    thr       = 5'd31;
    glitch    = 1'b0;
    n_chk     = 0;
    n_fail    = 0;

    // Reset state
    step();
    step();
    reset = 1'b0;
    chk("rst_dac", 32'(dac_code), 32'd0);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_over", 32'(over_range), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // comp tied high, one-cycle enable: trip at code 0 after 4 RAMP cycles
    enable = 1'b1;
    step();
    enable = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_dac", 32'(dac_code), 32'd0);
    wait_valid(200, cyc);
    chk("t1_latency", 32'(cyc), 32'd4);
    chk("t1_sample", 32'(sample), 32'd0);
    chk("t1_over", 32'(over_range), 32'd0);
    chk("t1_done_busy", 32'(busy), 32'd1);
    step();
    chk("t1_idle_valid", 32'(sample_valid), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // Threshold 9 through 2-flop delay, with a glitch on a non-sample cycle
    comp_mode = 0;
    thr       = 5'd9;
    repeat (3) step();
    enable = 1'b1;
    step();
    enable = 1'b0;
    ramp_check(40, 10);
    chk("t2_valid", 32'(sample_valid), 32'd1);
    chk("t2_sample", 32'(sample), 32'd9);
    chk("t2_over", 32'(over_range), 32'd0);
    step();
    chk("t2_idle_busy", 32'(busy), 32'd0);
    chk("t2_idle_dac", 32'(dac_code), 32'd0);

    // comp held low: saturate at 15 without wrapping, over_range set
    comp_mode = 2;
    enable = 1'b1;
    step();
    enable = 1'b0;
    ramp_check(64, -1);
    chk("t3_valid", 32'(sample_valid), 32'd1);
    chk("t3_sample", 32'(sample), 32'd15);
    chk("t3_over", 32'(over_range), 32'd1);
    step();
    chk("t3_idle_dac", 32'(dac_code), 32'd0);
    chk("t3_over_hold", 32'(over_range), 32'd1);
    chk("t3_sample_hold", 32'(sample), 32'd15);

    // enable held high, trip at code 3: valid every 17 cycles
    comp_mode = 0;
    thr       = 5'd3;
    repeat (3) step();
    enable = 1'b1;
    step();
    wait_valid(200, cyc);
    chk("t4_first_latency", 32'(cyc), 32'd16);
    chk("t4_first_sample", 32'(sample), 32'd3);
    chk("t4_first_over", 32'(over_range), 32'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("t4_restart_dac_%0d", k), 32'(dac_code), 32'd0);
      chk($sformatf("t4_restart_busy_%0d", k), 32'(busy), 32'd1);
      chk($sformatf("t4_restart_novalid_%0d", k), 32'(sample_valid), 32'd0);
      wait_valid(200, cyc);
      chk($sformatf("t4_period_%0d", k), 32'(cyc + 1), 32'd17);
      chk($sformatf("t4_sample_%0d", k), 32'(sample), 32'd3);
    end
    enable = 1'b0;
    step();
    chk("t4_stop_busy", 32'(busy), 32'd0);

    // enable dropped mid-ramp, trip at code 6: conversion completes, then IDLE
    thr = 5'd6;
    repeat (3) step();
    enable = 1'b1;
    step();
    repeat (10) step();
    enable = 1'b0;
    chk("t5_still_busy", 32'(busy), 32'd1);
    wait_valid(200, cyc);
    chk("t5_latency", 32'(cyc + 10), 32'd28);
    chk("t5_sample", 32'(sample), 32'd6);
    step();
    chk("t5_idle_busy", 32'(busy), 32'd0);
    repeat (5) step();
    chk("t5_stay_idle_busy", 32'(busy), 32'd0);
    chk("t5_stay_idle_dac", 32'(dac_code), 32'd0);

    // reset (with enable high) mid-RAMP at code 5
    thr = 5'd12;
    enable = 1'b1;
    step();
    enable = 1'b0;
    repeat (21) step();
    chk("t6_pre_dac", 32'(dac_code), 32'd5);
    reset  = 1'b1;
    enable = 1'b1;
    step();
    reset  = 1'b0;
    enable = 1'b0;
    chk("t6_dac", 32'(dac_code), 32'd0);
    chk("t6_sample", 32'(sample), 32'd0);
    chk("t6_valid", 32'(sample_valid), 32'd0);
    chk("t6_over", 32'(over_range), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (sample_valid !== 1'b0 || busy !== 1'b0 || dac_code !== '0) bad++;
    end
    chk("t6_no_resume", 32'(bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
